hazard_stall_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Drives PCWrite, IF_IDWrite and
//  IF_ID_Flush of the IF/ID register and the bubble control of ID/EX. Arbitrates between

---
 rtl/hazard_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Central stall/flush controller for the 5-stage pipeline, located in ID.
//   It arbitrates four hazard sources, from highest to lowest priority:
//     1. instruction-memory miss
//     2. load-use hazard
//     3. mult/div occupancy
//     4. branch/jump redirect
//   From the winner it drives the PC enable, the IF/ID load and flush
//   controls, and the ID/EX bubble.
//
//   Optional feature: define HAZARD_PERF_EN to add the saturating
//   performance counters stall_cycles and flush_count.
//
// Ports
//   clock, reset       pipeline clock (rising edge); async active-high reset
//   imem_ready         fetch returned valid data this cycle
//   ID_rs/ID_rt        source specifiers of the instruction in ID
//   ID_uses_rt         the ID instruction really reads rt
//   EX_MemRead/EX_rt   load in EX and its destination register
//   ID_redirect        branch taken or jump resolved in ID
//   ID_md_start        ID instruction is mult/div
//   ID_md_read         ID instruction is mfhi/mflo
//   PCWrite            PC update enable
//   IF_IDWrite         IF/ID load enable
//   IF_ID_Flush        IF/ID clear
//   ID_EX_Bubble       ID/EX control-field bubble
//   md_busy            mult/div unit occupied
//   stall_cycles       cycles with PCWrite=0       (HAZARD_PERF_EN only)
//   flush_count        cycles with IF_ID_Flush=1   (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             ID_redirect,
  input  logic             ID_md_start,
  input  logic             ID_md_read,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_IMISS   = 2'd1;
  localparam logic [1:0] ST_MD_WAIT = 2'd2;

  logic [1:0]       state, next_state;
  logic [MDC_W-1:0] md_cnt;
  logic             miss, load_use, md_haz, stall, md_accept;

  // Hazard detection. Register 0 never creates a load-use dependency.
  assign miss     = !imem_ready;
  assign load_use = EX_MemRead && (EX_rt != '0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
  assign md_haz   = md_busy && (ID_md_read || ID_md_start);
  assign stall    = miss || load_use || md_haz;

  // A mult/div only issues when ID actually advances. A redirect in the
  // same cycle (delay-slot pair) does not block it.
  assign md_accept = ID_md_start && !stall;

  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    next_state   = ST_RUN;

    if (miss)        next_state = ST_IMISS;
    else if (md_haz) next_state = ST_MD_WAIT;

    if (reset) begin
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (stall) begin
      // A stalled redirect stays held in IF/ID. Its flush fires on the
      // first cycle in which no stall is active.
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_redirect) begin
      IF_IDWrite   = 1'b0;
      IF_ID_Flush  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= next_state;
  end

  // md_busy stays high for MD_LATENCY cycles after issue. The counter
  // reaches 0 one cycle before busy drops, and it keeps running through
  // other stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else if (md_accept) begin
      md_cnt  <= MDC_W'(MD_LATENCY - 1);
      md_busy <= 1'b1;
    end else if (md_busy) begin
      if (md_cnt != '0) md_cnt  <= md_cnt - 1'b1;
      else              md_busy <= 1'b0;
    end
  end

  // The state register records why ID was held in the previous cycle.
  // These properties tie each recorded reason to the condition that
  // caused it.
  a_imiss_reason: assert property (@(posedge clock) disable iff (reset)
    (state == ST_IMISS) |-> $past(!imem_ready));
  a_mdwait_reason: assert property (@(posedge clock) disable iff (reset)
    (state == ST_MD_WAIT) |-> $past(md_busy));

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PCWrite && (stall_cycles != '1))    stall_cycles <= stall_cycles + 1'b1;
      if (IF_ID_Flush && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       imem_ready = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic       ID_uses_rt = 1'b0, EX_MemRead = 1'b0, ID_redirect = 1'b0;
  logic       ID_md_start = 1'b0, ID_md_read = 1'b0;
  logic       PCWrite, IF_IDWrite, IF_ID_Flush, ID_EX_Bubble, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_stall_ctrl #(.MD_LATENCY(32), .REG_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .imem_ready(imem_ready),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .ID_redirect(ID_redirect),
    .ID_md_start(ID_md_start), .ID_md_read(ID_md_read),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, rdy;
    logic [4:0] rs, rt;
    logic       urt, exmr;
    logic [4:0] ert;
    logic       redir, mds, mdr;
  } in_t;

  // Expected output vector: {PCWrite, IF_IDWrite, IF_ID_Flush, ID_EX_Bubble, md_busy}
  typedef struct {
    string      name;
    logic [4:0] e;
  } exp_t;

  localparam logic [4:0] E_RST   = 5'b00110;
  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00010;
  localparam logic [4:0] E_MDSTL = 5'b00011;
  localparam logic [4:0] E_FLUSH = 5'b10100;
  localparam logic [4:0] E_FLBSY = 5'b10101;
  localparam logic [4:0] E_RUNB  = 5'b11001;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  function automatic in_t nop();
    in_t i;
    i.rst = 1'b0; i.rdy = 1'b1; i.rs = '0; i.rt = '0; i.urt = 1'b0;
    i.exmr = 1'b0; i.ert = '0; i.redir = 1'b0; i.mds = 1'b0; i.mdr = 1'b0;
    return i;
  endfunction

  // Applies one cycle of inputs just after the rising edge and queues the
  // hand-computed outputs expected for that cycle.
  task automatic drive(input string name, input in_t i, input logic [4:0] e);
    exp_t x;
    @(posedge clock);
    #1;
    reset = i.rst; imem_ready = i.rdy; ID_rs = i.rs; ID_rt = i.rt;
    ID_uses_rt = i.urt; EX_MemRead = i.exmr; EX_rt = i.ert;
    ID_redirect = i.redir; ID_md_start = i.mds; ID_md_read = i.mdr;
    x.name = name; x.e = e;
    sb.push_back(x);
  endtask

  // Monitor: checks one queued expectation per cycle, on the falling edge.
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t x;
      logic [4:0] act;
      x = sb.pop_front();
      act = {PCWrite, IF_IDWrite, IF_ID_Flush, ID_EX_Bubble, md_busy};
      total++;
      if (act !== x.e) begin
        bad++;
        $display("FAIL %s: got pcw/ifw/fl/bub/busy=%b expected %b", x.name, act, x.e);
      end
    end
  end

  initial begin
    in_t i;

    // Reset state.
    i = nop(); i.rst = 1'b1;
    drive("reset0", i, E_RST);
    drive("reset1", i, E_RST);
    drive("run0", nop(), E_RUN);

    // Delay-slot pair: mult/div together with a redirect. Both take effect.
    i = nop(); i.mds = 1'b1; i.redir = 1'b1;
    drive("md_redir_pair", i, E_FLUSH);
    i = nop(); i.mdr = 1'b1;
    for (int k = 0; k < 3; k++) drive("md_wait_pre_reset", i, E_MDSTL);

    // Reset in the middle of MD_WAIT, then release it.
    i.rst = 1'b1;
    drive("reset_mid_md", i, E_RST);
    i.rst = 1'b0;
    drive("after_reset_md_clear", i, E_RUN);
    drive("run1", nop(), E_RUN);

    // Load-use on rs: exactly one stall cycle, after which the bubble clears EX.
    i = nop(); i.exmr = 1'b1; i.ert = 5'd5; i.rs = 5'd5;
    drive("loaduse_rs", i, E_STALL);
    i = nop(); i.rs = 5'd5;
    drive("loaduse_release", i, E_RUN);

    // Load-use on rt when rt is really read.
    i = nop(); i.exmr = 1'b1; i.ert = 5'd7; i.rt = 5'd7; i.rs = 5'd3; i.urt = 1'b1;
    drive("loaduse_rt", i, E_STALL);
    drive("run2", nop(), E_RUN);

    // Register 0 never causes a hazard; rt that is not read never causes one.
    i = nop(); i.exmr = 1'b1; i.ert = 5'd0; i.rs = 5'd0;
    drive("reg0_no_stall", i, E_RUN);
    i = nop(); i.exmr = 1'b1; i.ert = 5'd7; i.rt = 5'd7; i.rs = 5'd3;
    drive("rt_unused_no_stall", i, E_RUN);

    // A mult/div issued under a load-use stall is not accepted.
    i = nop(); i.exmr = 1'b1; i.ert = 5'd9; i.rs = 5'd9; i.mds = 1'b1;
    drive("md_under_stall", i, E_STALL);
    drive("md_not_accepted", nop(), E_RUN);

    // A miss dominates a redirect. The flush fires once, after the miss ends.
    i = nop(); i.rdy = 1'b0; i.redir = 1'b1;
    for (int k = 0; k < 3; k++) drive("miss_redir", i, E_STALL);
    i.rdy = 1'b1;
    drive("redir_after_miss", i, E_FLUSH);
    drive("run3", nop(), E_RUN);

    // mult, then mflo: 32 stall cycles, and mflo issues in cycle 33.
    i = nop(); i.mds = 1'b1;
    drive("mult_issue", i, E_RUN);
    i = nop(); i.mdr = 1'b1;
    for (int k = 0; k < 32; k++) drive("mflo_wait", i, E_MDSTL);
    drive("mflo_issue", i, E_RUN);

    // An unrelated instruction runs while the unit is busy; a redirect is also not blocked.
    i = nop(); i.mds = 1'b1;
    drive("mult2_issue", i, E_RUN);
    drive("indep_while_busy", nop(), E_RUNB);
    i = nop(); i.redir = 1'b1;
    drive("redir_while_busy", i, E_FLBSY);

    // Let the monitor drain the queue. The wait is bounded.
    for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clock);
    @(negedge clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

`ifdef HAZARD_PERF_EN
    // Since the mid-test reset: load-use 1+1+1, miss 3, mflo 32 give 38 stall
    // cycles; flushes come from the post-miss redirect and the last redirect.
    total++;
    if (stall_cycles !== 32'd38) begin
      bad++;
      $display("FAIL stall_cycles: got %0d expected 38", stall_cycles);
    end
    total++;
    if (flush_count !== 32'd2) begin
      bad++;
      $display("FAIL flush_count: got %0d expected 2", flush_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
